// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
// Holds the control FSM state encoding, the default operand width and the
// iteration-counter width helper used by divisor_secuencial and its interface.
package div_pkg;

  // Default operand width in bits (supported range 2..16).
  localparam int N_DEF = 4;

  // The counter must hold the value N itself, hence one bit beyond clog2(N).
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(N_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPERA = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage

// File: rtl/divisor_secuencial_if.sv
// divisor_secuencial_if: start/fin handshake and operand/result bundle.
//   start      request, sampled only while the divider is idle
//   dividendo  unsigned dividend, sampled with start
//   divisor    unsigned divisor, sampled with start
//   cociente   registered quotient, held until the next completion
//   resto      registered remainder, held until the next completion
//   ocupado    division in progress (including the completion cycle)
//   fin        one-cycle completion pulse
//   div_cero   registered flag: the last result had a zero divisor
// master = requester side, slave = divider side.
interface divisor_secuencial_if import div_pkg::*; #(
  parameter int N = N_DEF
) ();

  logic         start;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] resto;
  logic         ocupado;
  logic         fin;
  logic         div_cero;

  modport master (
    output start, dividendo, divisor,
    input  cociente, resto, ocupado, fin, div_cero
  );

  modport slave (
    input  start, dividendo, divisor,
    output cociente, resto, ocupado, fin, div_cero
  );

endinterface

// File: rtl/registro_aq.sv
// registro_aq: (2N+1)-bit shift register holding {A,Q} for the divider.
//   clk          rising-edge clock
//   reset        asynchronous active-low reset, clears the register
//   carga        parallel load of dato (has priority over desplaza)
//   desplaza     shift left by one, bit_en_desp enters at bit 0 (Q[0])
//   bit_en_desp  serial input bit for the shift
//   dato         parallel load value
//   aq           current register contents
module registro_aq #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         carga,
  input  logic         desplaza,
  input  logic         bit_en_desp,
  input  logic [2*N:0] dato,
  output logic [2*N:0] aq
);

  logic [2*N:0] aq_q;
  logic [2*N:0] aq_d;

  // Next-value selection: load, shift or hold.
  always_comb begin
    aq_d = aq_q;
    if (carga) begin
      aq_d = dato;
    end else if (desplaza) begin
      aq_d = {aq_q[2*N-1:0], bit_en_desp};
    end else begin
      aq_d = aq_q;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aq_q <= '0;
    end else begin
      aq_q <= aq_d;
    end
  end

  assign aq = aq_q;

endmodule

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential restoring divider for unsigned N-bit operands.
// One shift-subtract iteration per clock; quotient/remainder are registered and
// announced with a one-cycle fin pulse. A zero divisor skips the iterations and
// returns all-ones quotient with the dividend as remainder and div_cero set.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    handshake/operand/result bundle (slave side)
module divisor_secuencial import div_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  divisor_secuencial_if.slave  bus
);

  localparam int CNT_W = cnt_width(N);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       m_q, m_d;
  logic               dz_q, dz_d;
  logic [N-1:0]       cociente_q, cociente_d;
  logic [N-1:0]       resto_q, resto_d;
  logic               div_cero_q, div_cero_d;
  logic               fin_q, fin_d;
  logic               ocupado_q, ocupado_d;

  logic               carga_s;
  logic               desplaza_s;
  logic               bit_s;
  logic [2*N:0]       dato_s;
  logic [2*N:0]       aq_s;
  logic [N:0]         a_sh_s;
  logic [N:0]         t_s;
  logic               unused_s;

  registro_aq #(.N(N)) u_registro_aq (
    .clk         (clk),
    .reset       (reset),
    .carga       (carga_s),
    .desplaza    (desplaza_s),
    .bit_en_desp (bit_s),
    .dato        (dato_s),
    .aq          (aq_s)
  );

  // A after the left shift of {A,Q}; the old A sign bit falls off the top.
  // It is always 0 here because A stays below M between iterations.
  assign a_sh_s   = aq_s[2*N-1:N-1];
  assign t_s      = a_sh_s - {1'b0, m_q};
  assign unused_s = aq_s[2*N];

  // Next-state, datapath control and result update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    dz_d       = dz_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    div_cero_d = div_cero_q;
    carga_s    = 1'b0;
    desplaza_s = 1'b0;
    bit_s      = 1'b0;
    dato_s     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          carga_s = 1'b1;
          dato_s  = {{(N+1){1'b0}}, bus.dividendo};
          if (bus.divisor != '0) begin
            m_d     = bus.divisor;
            cnt_d   = CNT_W'(N);
            dz_d    = 1'b0;
            state_d = OPERA;
          end else begin
            dz_d    = 1'b1;
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OPERA: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (t_s[N]) begin
          // Trial subtraction went negative: restore by plain shift, Q[0]=0.
          desplaza_s = 1'b1;
          bit_s      = 1'b0;
        end else begin
          // Keep the difference as the new A and shift in a quotient 1.
          carga_s = 1'b1;
          dato_s  = {t_s, aq_s[N-2:0], 1'b1};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
        end else begin
          state_d = OPERA;
        end
      end
      FIN: begin
        if (dz_q) begin
          cociente_d = '1;
          resto_d    = aq_s[N-1:0];
        end else begin
          cociente_d = aq_s[N-1:0];
          resto_d    = aq_s[2*N-1:N];
        end
        div_cero_d = dz_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fin_d     = (state_q == FIN);
  assign ocupado_d = (state_d != IDLE);

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      m_q        <= '0;
      dz_q       <= 1'b0;
      cociente_q <= '0;
      resto_q    <= '0;
      div_cero_q <= 1'b0;
      fin_q      <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      dz_q       <= dz_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      div_cero_q <= div_cero_d;
      fin_q      <= fin_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign bus.cociente = cociente_q;
  assign bus.resto    = resto_q;
  assign bus.div_cero = div_cero_q;
  assign bus.fin      = fin_q;
  assign bus.ocupado  = ocupado_q;

endmodule
